// File: rtl/gpu_lsu_requester.sv
// ---------------------------------------------------------------------------
// gpu_lsu_requester
//
// Four-lane load/store requester for one GPU core. It accepts one vector
// command, issues per-lane requests to a quad-port data RAM, gathers load
// results, and returns a single completion response. A cycle counter aborts
// the command with resp_error if a lane never answers.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid / req_ready     command handshake
//   req_is_store              1 = store, 0 = load
//   req_lane_mask [3:0]       active lanes
//   req_addrN / req_wdataN    per-lane word address / store data
//   resp_valid / resp_ready   completion handshake
//   resp_error                command aborted by timeout
//   resp_rdataN               per-lane load data (0 for inactive lanes)
//   mem_read_valid  [3:0]     per-lane read request
//   mem_write_valid [3:0]     per-lane write request
//   raddrN / waddrN / data_inN  request address / store data
//   mem_read_ready  [3:0]     per-lane read done, data_outN valid with it
//   mem_write_ready [3:0]     per-lane write done
//   data_outN                 read data
//   dbg_state [1:0]           current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshakes: a command transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where resp_valid && resp_ready. A valid,
// once raised, holds its payload stable until the transfer. Memory requests
// are per lane: a lane stays requested until its ready is seen while the lane
// is still pending; ready on a lane that is not pending is ignored.
// ---------------------------------------------------------------------------
module gpu_lsu_requester #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [3:0]            req_lane_mask,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [ADDR_WIDTH-1:0] req_addr2,
    input  logic [ADDR_WIDTH-1:0] req_addr3,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    input  logic [DATA_WIDTH-1:0] req_wdata2,
    input  logic [DATA_WIDTH-1:0] req_wdata3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_error,
    output logic [DATA_WIDTH-1:0] resp_rdata0,
    output logic [DATA_WIDTH-1:0] resp_rdata1,
    output logic [DATA_WIDTH-1:0] resp_rdata2,
    output logic [DATA_WIDTH-1:0] resp_rdata3,
    output logic [3:0]            mem_read_valid,
    output logic [3:0]            mem_write_valid,
    output logic [ADDR_WIDTH-1:0] raddr0,
    output logic [ADDR_WIDTH-1:0] raddr1,
    output logic [ADDR_WIDTH-1:0] raddr2,
    output logic [ADDR_WIDTH-1:0] raddr3,
    output logic [ADDR_WIDTH-1:0] waddr0,
    output logic [ADDR_WIDTH-1:0] waddr1,
    output logic [ADDR_WIDTH-1:0] waddr2,
    output logic [ADDR_WIDTH-1:0] waddr3,
    output logic [DATA_WIDTH-1:0] data_in0,
    output logic [DATA_WIDTH-1:0] data_in1,
    output logic [DATA_WIDTH-1:0] data_in2,
    output logic [DATA_WIDTH-1:0] data_in3,
    input  logic [3:0]            mem_read_ready,
    input  logic [3:0]            mem_write_ready,
    input  logic [DATA_WIDTH-1:0] data_out0,
    input  logic [DATA_WIDTH-1:0] data_out1,
    input  logic [DATA_WIDTH-1:0] data_out2,
    input  logic [DATA_WIDTH-1:0] data_out3,
    output logic [1:0]            dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  is_store_q;
    logic [3:0]            pending_q;
    logic [CW-1:0]         cnt_q;
    logic                  error_q;
    logic [ADDR_WIDTH-1:0] addr_q  [4];
    logic [DATA_WIDTH-1:0] wdata_q [4];
    logic [DATA_WIDTH-1:0] rdata_q [4];

    logic [ADDR_WIDTH-1:0] req_addr_a  [4];
    logic [DATA_WIDTH-1:0] req_wdata_a [4];
    logic [DATA_WIDTH-1:0] data_out_a  [4];

    logic [3:0] lane_done;
    logic [3:0] pending_next;
    logic       timeout_hit;

    assign req_addr_a[0]  = req_addr0;
    assign req_addr_a[1]  = req_addr1;
    assign req_addr_a[2]  = req_addr2;
    assign req_addr_a[3]  = req_addr3;
    assign req_wdata_a[0] = req_wdata0;
    assign req_wdata_a[1] = req_wdata1;
    assign req_wdata_a[2] = req_wdata2;
    assign req_wdata_a[3] = req_wdata3;
    assign data_out_a[0]  = data_out0;
    assign data_out_a[1]  = data_out1;
    assign data_out_a[2]  = data_out2;
    assign data_out_a[3]  = data_out3;

    // Only the ready that matches the command type and a still-pending lane
    // counts; this discards the stale ready from the RAM's trailing access.
    assign lane_done    = pending_q & (is_store_q ? mem_write_ready : mem_read_ready);
    assign pending_next = pending_q & ~lane_done;
    assign timeout_hit  = (cnt_q == CNT_LAST) && (pending_next != 4'b0);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FSM-decoded outputs. All request outputs derive from
    // registered state, so no memory ready reaches a memory valid
    // combinationally.
    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        mem_read_valid  = 4'b0;
        mem_write_valid = 4'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (req_lane_mask == 4'b0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (is_store_q) begin
                    mem_write_valid = pending_q;
                end else begin
                    mem_read_valid = pending_q;
                end
                if (pending_next == 4'b0 || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, lane tracking, load data gather and timeout counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            is_store_q <= 1'b0;
            pending_q  <= 4'b0;
            cnt_q      <= '0;
            error_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        pending_q  <= req_lane_mask;
                        cnt_q      <= '0;
                        error_q    <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            addr_q[i]  <= req_addr_a[i];
                            wdata_q[i] <= req_wdata_a[i];
                            rdata_q[i] <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    pending_q <= pending_next;
                    cnt_q     <= cnt_q + 1'b1;
                    if (timeout_hit) begin
                        error_q <= 1'b1;
                    end
                    for (int i = 0; i < 4; i++) begin
                        if (lane_done[i] && !is_store_q) begin
                            rdata_q[i] <= data_out_a[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_error  = error_q;
    assign resp_rdata0 = rdata_q[0];
    assign resp_rdata1 = rdata_q[1];
    assign resp_rdata2 = rdata_q[2];
    assign resp_rdata3 = rdata_q[3];

    // Loads and stores share one latched address set per lane.
    assign raddr0   = addr_q[0];
    assign raddr1   = addr_q[1];
    assign raddr2   = addr_q[2];
    assign raddr3   = addr_q[3];
    assign waddr0   = addr_q[0];
    assign waddr1   = addr_q[1];
    assign waddr2   = addr_q[2];
    assign waddr3   = addr_q[3];
    assign data_in0 = wdata_q[0];
    assign data_in1 = wdata_q[1];
    assign data_in2 = wdata_q[2];
    assign data_in3 = wdata_q[3];

    assign dbg_state = state_q;

endmodule
